// File: rtl/au_arb_pkg.sv
// Shared types and constants for the two-requester arithmetic-unit arbiter.
// Pure definitions: no logic, no latency, no flow control.
package au_arb_pkg;

   localparam int WIDTH_DEF = 4;

   localparam logic [1:0] SEL_ADD = 2'b00;
   localparam logic [1:0] SEL_SUB = 2'b01;
   localparam logic [1:0] SEL_AND = 2'b10;
   localparam logic [1:0] SEL_XOR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/arithmetic_unit.sv
// Combinational signed add/sub/and/xor with two's-complement overflow flag.
// Zero latency; no flow control, operands must be held stable by the caller.
module arithmetic_unit
   import au_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic signed [WIDTH-1:0] A,
   input  logic signed [WIDTH-1:0] B,
   input  logic        [1:0]       sel,
   output logic signed [WIDTH-1:0] q,
   output logic                    overflow
);

   logic signed [WIDTH-1:0] res;

   always_comb begin
      res      = '0;
      overflow = 1'b0;
      case (sel)
         SEL_ADD: begin
            res      = A + B;
            overflow = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
         end
         SEL_SUB: begin
            res      = A - B;
            overflow = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
         end
         SEL_AND: res = A & B;
         default: res = A ^ B;
      endcase
   end

   assign q = res;

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to prio.
// Zero latency; gnt is meaningless when neither requester is valid.
module rr_arb2 (
   input  logic req0_valid,
   input  logic req1_valid,
   input  logic prio,
   output logic gnt
);

   assign gnt = (req0_valid && req1_valid) ? prio : (req1_valid && !req0_valid);

endmodule

// File: rtl/au_share_arbiter.sv
// Shares one arithmetic_unit between two valid/ready requesters, round-robin.
// Request to response valid in 2 cycles; RESP holds until the winner's rsp_ready.
module au_share_arbiter
   import au_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req0_valid,
   output logic                    req0_ready,
   input  logic signed [WIDTH-1:0] req0_a,
   input  logic signed [WIDTH-1:0] req0_b,
   input  logic        [1:0]       req0_sel,
   input  logic                    req1_valid,
   output logic                    req1_ready,
   input  logic signed [WIDTH-1:0] req1_a,
   input  logic signed [WIDTH-1:0] req1_b,
   input  logic        [1:0]       req1_sel,
   output logic                    rsp0_valid,
   input  logic                    rsp0_ready,
   output logic                    rsp1_valid,
   input  logic                    rsp1_ready,
   output logic signed [WIDTH-1:0] rsp_q,
   output logic                    rsp_ov,
   output logic                    busy,
   output logic        [CNT_W-1:0] ops_done
);

   state_t                  state_q, state_d;
   logic                    prio_q, prio_d;
   logic                    gnt_id_q, gnt_id_d;
   logic signed [WIDTH-1:0] op_a_q, op_a_d;
   logic signed [WIDTH-1:0] op_b_q, op_b_d;
   logic        [1:0]       op_sel_q, op_sel_d;
   logic signed [WIDTH-1:0] res_q, res_d;
   logic                    ov_q, ov_d;
   logic        [CNT_W-1:0] ops_done_q, ops_done_d;

   logic                    gnt;
   logic signed [WIDTH-1:0] au_q;
   logic                    au_ov;

   rr_arb2 u_arb (
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .prio       (prio_q),
      .gnt        (gnt)
   );

   // Fed only from the latched operands so the datapath never sees requester changes.
   arithmetic_unit #(.WIDTH(WIDTH)) u_au (
      .A        (op_a_q),
      .B        (op_b_q),
      .sel      (op_sel_q),
      .q        (au_q),
      .overflow (au_ov)
   );

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      gnt_id_d   = gnt_id_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_sel_d   = op_sel_q;
      res_d      = res_q;
      ov_d       = ov_q;
      ops_done_d = ops_done_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req0_ready = !gnt && req0_valid;
            req1_ready = gnt && req1_valid;
            if (req0_ready || req1_ready) begin
               gnt_id_d = gnt;
               op_a_d   = gnt ? req1_a   : req0_a;
               op_b_d   = gnt ? req1_b   : req0_b;
               op_sel_d = gnt ? req1_sel : req0_sel;
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            res_d   = au_q;
            ov_d    = au_ov;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp0_valid = !gnt_id_q;
            rsp1_valid = gnt_id_q;
            if (gnt_id_q ? rsp1_ready : rsp0_ready) begin
               prio_d     = !gnt_id_q;
               ops_done_d = ops_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         prio_q     <= 1'b0;
         gnt_id_q   <= 1'b0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_sel_q   <= '0;
         res_q      <= '0;
         ov_q       <= 1'b0;
         ops_done_q <= '0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         gnt_id_q   <= gnt_id_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_sel_q   <= op_sel_d;
         res_q      <= res_d;
         ov_q       <= ov_d;
         ops_done_q <= ops_done_d;
      end
   end

   assign rsp_q    = res_q;
   assign rsp_ov   = ov_q;
   assign busy     = (state_q != ST_IDLE);
   assign ops_done = ops_done_q;

endmodule

// File: tb/tb_au_share_arbiter.sv
// Directed bench: stimulus pushes expected responses, a monitor pops them on handshakes.
module tb_au_share_arbiter;
   import au_arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid, req0_ready, req1_ready;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0] req0_sel, req1_sel;
   logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [3:0] rsp_q;
   logic       rsp_ov, busy;
   logic [7:0] ops_done;

   logic       w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid, w_rsp_ov, w_busy;
   logic [3:0] w_rsp_q;
   logic [1:0] w_ops_done;

   typedef struct packed {
      logic       ch;
      logic [3:0] q;
      logic       ov;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   exp_done = 0;

   always #5 clk = ~clk;

   au_share_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_q(rsp_q), .rsp_ov(rsp_ov), .busy(busy), .ops_done(ops_done)
   );

   // Narrow-counter copy driven by the same stimulus, used only for the wrap check.
   au_share_arbiter #(.WIDTH(4), .CNT_W(2)) dut_w (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .rsp0_valid(w_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(w_rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_q(w_rsp_q), .rsp_ov(w_rsp_ov), .busy(w_busy), .ops_done(w_ops_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp0_valid && rsp1_valid) chk("both_rsp_valid", 1, 0);
         if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rsp_channel", {31'd0, rsp1_valid}, {31'd0, e.ch});
               chk("rsp_q_ov", {27'd0, rsp_q, rsp_ov}, {27'd0, e.q, e.ov});
            end
         end
      end
   end

   // Drives one request from the cycle after the next rising edge; the expected
   // response is queued at the sampled handshake.
   task automatic issue(input logic ch, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] sel, input logic [3:0] eq, input logic eov,
                        output int wait_cyc);
      exp_t e;
      logic rdy;
      @(posedge clk); #1;
      if (ch) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel; end
      wait_cyc = 0;
      forever begin
         @(negedge clk);
         rdy = ch ? req1_ready : req0_ready;
         if (rdy) break;
         wait_cyc++;
         if (wait_cyc > 50) begin
            chk("req_timeout", 1, 0);
            break;
         end
      end
      if (rdy) begin
         e.ch = ch; e.q = eq; e.ov = eov;
         exp_q.push_back(e);
         exp_done++;
      end
      @(posedge clk); #1;
      if (ch) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic wait_idle(output int s0, output int s1);
      s0 = 0; s1 = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (rsp0_valid) s0++;
         if (rsp1_valid) s1++;
         if (!busy) break;
      end
      chk("idle_timeout", {31'd0, busy}, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      exp_done = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct packed {
      logic       ch;
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] sel;
      logic [3:0] q;
      logic       ov;
   } vec_t;

   vec_t wrap_vec[5];

   initial begin
      int w0, w1, s0, s1, bad;
      wrap_vec[0] = '{1'b0, 4'd5,  4'd3,  SEL_SUB, 4'd2,  1'b0};
      wrap_vec[1] = '{1'b1, 4'h8,  4'd1,  SEL_SUB, 4'd7,  1'b1};
      wrap_vec[2] = '{1'b0, 4'hC,  4'hA,  SEL_AND, 4'h8,  1'b0};
      wrap_vec[3] = '{1'b1, 4'hC,  4'hA,  SEL_XOR, 4'h6,  1'b0};
      wrap_vec[4] = '{1'b0, 4'hD,  4'hC,  SEL_ADD, 4'h9,  1'b0};

      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0;
      req0_a = 0; req0_b = 0; req0_sel = 0;
      req1_a = 0; req1_b = 0; req1_sel = 0;
      rsp0_ready = 0; rsp1_ready = 0;

      #12;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_valids_readies", {28'd0, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 0);
      chk("rst_rsp", {27'd0, rsp_q, rsp_ov}, 0);
      chk("rst_ops_done", {24'd0, ops_done}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request with the response taken immediately.
      rsp0_ready = 1'b1;
      issue(1'b0, 4'd3, 4'd2, SEL_ADD, 4'd5, 1'b0, w0);
      chk("single_ready_edge0", w0, 0);
      @(negedge clk);
      chk("single_exec_busy", {30'd0, busy, rsp0_valid}, 32'h2);
      @(negedge clk);
      chk("single_rsp_valid", {31'd0, rsp0_valid}, 1);
      @(posedge clk); #1;
      chk("single_ops_done", {24'd0, ops_done}, 1);
      chk("single_back_idle", {31'd0, busy}, 0);

      // Overflow on channel 1; channel 0 must never respond.
      rsp1_ready = 1'b1;
      issue(1'b1, 4'd7, 4'd1, SEL_ADD, 4'h8, 1'b1, w1);
      wait_idle(s0, s1);
      chk("ovf_rsp0_silent", s0, 0);
      chk("ovf_rsp1_cycles", s1, 1);

      // Contention from reset: req0 first, req1 waits through one full operation.
      do_reset();
      fork
         issue(1'b0, 4'd1, 4'd1, SEL_ADD, 4'd2, 1'b0, w0);
         issue(1'b1, 4'd2, 4'd2, SEL_ADD, 4'd4, 1'b0, w1);
      join
      wait_idle(s0, s1);
      chk("cont_req0_wait", w0, 0);
      chk("cont_req1_wait", w1, 3);
      chk("cont_ops_done", {24'd0, ops_done}, 2);

      // A lone req0 hands priority to req1 for the next tie.
      issue(1'b0, 4'd3, 4'd3, SEL_ADD, 4'd6, 1'b0, w0);
      wait_idle(s0, s1);
      fork
         issue(1'b0, 4'd1, 4'd2, SEL_ADD, 4'd3, 1'b0, w0);
         issue(1'b1, 4'd3, 4'd4, SEL_ADD, 4'd7, 1'b0, w1);
      join
      wait_idle(s0, s1);
      chk("rr_req1_wait", w1, 0);
      chk("rr_req0_wait", w0, 3);

      // Backpressure on rsp0 while req1 waits.
      rsp0_ready = 1'b0;
      issue(1'b0, 4'd2, 4'd3, SEL_ADD, 4'd5, 1'b0, w0);
      req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'hE; req1_sel = SEL_ADD;
      @(negedge clk);
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (!(rsp0_valid && busy && !req1_ready && rsp_q == 4'd5 && !rsp_ov && ops_done == 8'd5)) bad++;
         if (i < 4) @(negedge clk);
      end
      chk("bp_hold_stable", bad, 0);
      @(posedge clk); #1;
      rsp0_ready = 1'b1;
      chk("bp_still_resp", {31'd0, busy}, 1);
      @(posedge clk); #1;
      chk("bp_ops_done", {24'd0, ops_done}, 6);
      chk("bp_req1_ready_after", {31'd0, req1_ready}, 1);
      exp_q.push_back('{1'b1, 4'd4, 1'b0});
      exp_done++;
      @(posedge clk); #1;
      req1_valid = 1'b0;
      wait_idle(s0, s1);
      chk("bp_req1_result_seen", s1, 1);

      // Reset during EXEC drops the operation.
      issue(1'b0, 4'd1, 4'd2, SEL_ADD, 4'd3, 1'b0, w0);
      rst_n = 1'b0;
      exp_q.delete();
      exp_done = 0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 0);
      chk("midrst_rsp", {27'd0, rsp_q, rsp_ov}, 0);
      chk("midrst_ops_done", {24'd0, ops_done}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp0_valid || rsp1_valid || busy) bad++;
      end
      chk("midrst_no_rsp", bad, 0);

      // Five operations: narrow counter wraps to 1.
      for (int i = 0; i < 5; i++) begin
         issue(wrap_vec[i].ch, wrap_vec[i].a, wrap_vec[i].b, wrap_vec[i].sel,
               wrap_vec[i].q, wrap_vec[i].ov, w0);
         wait_idle(s0, s1);
      end
      chk("wrap_ops_done8", {24'd0, ops_done}, exp_done);
      chk("wrap_ops_done2", {30'd0, w_ops_done}, 1);

      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
